out_scheduler: RTL and testbench
================================

# out_scheduler

Parametrised N-channel time-multiplexer for the display output path. It rotates round-robin through `CHANNELS` input words of `WIDTH` bits and holds each one on a registered output for `DWELL` clocks. Disabled channels are skipped. It reports which channel is currently driven and pulses once per full rotation. It sits between the per-function data sources (time, display-point, etc.) and the display driver, and replaces fixed two-channel alternation.

## Interface
- `WIDTH`, 4, bits per channel word
- `CHANNELS`, 4, number of input channels (2..16)
- `DWELL`, 4, clocks each channel is shown (>= 1)
- `SEL_W`, `$clog2(CHANNELS)`, derived; not overridden
- `clk_o` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `in_data` input `CHANNELS*WIDTH`: channel k occupies bits `[k*WIDTH +: WIDTH]`
- `en_mask` input `CHANNELS`: bit k = 1 includes channel k in rotation
- `hold` input 1: freeze rotation (dwell counter and selection)
- `out_c` output `WIDTH`: registered word of the displayed channel
- `out_sel` output `SEL_W`: channel index shown on `out_c`, aligned with it
- `out_valid` output 1: 1 when `out_c` carries channel data (not blank or idle)
- `frame_start` output 1: one-cycle pulse on the first cycle the rotation wraps to a new pass

## Operation
- Internal state: `sel` (`SEL_W`) and dwell counter `cnt` (counts 0..`DWELL`-1).
- Each cycle, the registered outputs load as follows:
  - `out_c <= en_mask[sel] ? in_data[sel] : 0`
  - `out_sel <= sel`
  - `out_valid <= en_mask[sel]`
- Advance condition: `!hold && (en_mask != 0) && (cnt == DWELL-1 || !en_mask[sel])`.
- On advance:
  - `sel` goes to the next set bit of `en_mask` strictly after `sel`, in circular order. If `sel` is the only enabled channel, it stays.
  - `cnt` <= 0.
  - If the new `sel` <= old `sel` (wrap), `frame_start` is asserted together with the first `out_c` of the new channel.
- Otherwise, if `!hold` and `en_mask != 0`, `cnt` increments.
- `en_mask == 0`: idle. `sel` and `cnt` hold, `out_c` = 0, `out_valid` = 0, no `frame_start`.
- `hold` = 1: `sel` and `cnt` freeze. `out_c` keeps tracking live `in_data[sel]`. `hold` has priority over a mask-forced advance.
- `en_mask` changing mid-dwell:
  - If the current channel becomes disabled, the block advances on the next edge.
  - Newly enabled channels join when the rotation reaches them.
- Input words are not latched. `out_c` follows `in_data` changes with 1-cycle latency, even mid-dwell.

## Timing
- Reset (`rst` high at an edge): `sel`=0, `cnt`=0, `out_c`=0, `out_sel`=0, `out_valid`=0, `frame_start`=0. Reset mid-dwell aborts immediately.
- First edge after reset release: `out_c` = channel 0 word if `en_mask[0]`. If channel 0 is disabled, `sel` advances on that same edge.
- Latency: `in_data`/`en_mask` to `out_c` is 1 clock. A `sel` change appears on `out_sel` 1 clock later.
- Steady state, all channels enabled: each channel is valid for exactly `DWELL` consecutive cycles, and a full pass is `CHANNELS*DWELL` cycles.
- `DWELL`=1: the channel changes every cycle.
- `frame_start` never asserts on the cycle after reset. The initial pass does not count as a wrap.

## Configuration
- `OUT_SCHED_BLANK_EN` defined: one blank cycle is inserted on every advance, for anti-ghosting on multiplexed digits.
  - During the blank cycle: `out_c`=0, `out_valid`=0, `out_sel` = new channel.
  - `frame_start` is delayed to the first valid cycle of the new channel.
  - Per-channel period becomes `DWELL`+1.
  - `hold` asserted during the blank cycle extends the blank.
- Undefined: no blank cycle; behaviour is as above.

## Structure
- Package `out_sched_pkg` holds the default `WIDTH`/`CHANNELS`/`DWELL` constants and a `next_enabled(mask, cur)` function for circular priority search.
- Sub-module `dwell_timer` provides the `cnt` counter with `load`/`en` inputs and a terminal-count output. The mux, selection and output registers stay in `out_scheduler`.

## Test plan
- Reset, `WIDTH`=4, `CHANNELS`=4, `DWELL`=4, mask 4'b1111, inputs 1,2,3,4: expect `out_c` 1,1,1,1,2,2,2,2,3,…; `frame_start` on the first cycle of the second "1".
- Mask 4'b1010: expect `out_c` to alternate 2 (×4) and 4 (×4) with `out_sel` 1/3; channels 0/2 never appear.
- Mask drops bit 1 on cycle 2 of channel 1's dwell: expect channel 2 on `out_c` two cycles later; mask 0 gives `out_c`=0, `out_valid`=0.
- `hold` asserted for 5 cycles mid-dwell while `in_data[k]` changes 3→7: `out_c` changes to 7 with 1-cycle lag; dwell resumes with the remaining count.
- `rst` pulsed mid-dwell on channel 2: next cycle `out_c`=0, `out_sel`=0; rotation restarts from channel 0.
- With `OUT_SCHED_BLANK_EN`: expect sequence 1×4, 0 (`out_valid`=0), 2×4, 0, …; period 5 per channel.

Source files
------------

// File: rtl/out_sched_pkg.sv
// out_sched_pkg: default sizing and circular next-enabled-channel search for out_scheduler.
package out_sched_pkg;
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DWELL    = 4;

    // First set bit strictly after cur in circular order over n channels; cur itself if it is the only one.
    function automatic logic [3:0] next_enabled(input logic [15:0] mask, input logic [3:0] cur, input int n);
        logic [3:0] r;
        int idx;
        r = cur;
        for (int i = n; i >= 1; i--) begin
            idx = (int'(cur) + i) % n;
            if (mask[idx]) r = idx[3:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: per-channel dwell counter, cleared by load, advanced by en, flags the last dwell clock.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk_o,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_o) begin
        if (rst || load) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    assign tc = cnt == CW'(DWELL - 1);
endmodule

// File: rtl/out_scheduler.sv
// out_scheduler: round-robin time-multiplexer of CHANNELS words onto one registered output.
// Define OUT_SCHED_BLANK_EN to insert one blank cycle on every channel advance.
module out_scheduler
    import out_sched_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DWELL    = DEF_DWELL,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk_o,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       en_mask,
    input  logic                      hold,
    output logic [WIDTH-1:0]          out_c,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    output logic                      frame_start
);
    logic [SEL_W-1:0] sel, nxt;
    logic [WIDTH-1:0] cur_word;
    logic any, cur_en, run, adv, wrap, tc, blank, pend;
    always_comb begin
        any = |en_mask;
        cur_en = en_mask[sel];
        cur_word = in_data[sel*WIDTH +: WIDTH];
        run = !hold && any && !blank;
        adv = run && (tc || !cur_en);
        nxt = SEL_W'(next_enabled(16'(en_mask), 4'(sel), CHANNELS));
        wrap = adv && nxt <= sel;
    end
    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk_o (clk_o),
        .rst   (rst),
        .load  (adv),
        .en    (run),
        .tc    (tc)
    );
`ifdef OUT_SCHED_BLANK_EN
    // hold keeps the blank going so a frozen display stays dark between channels
    always_ff @(posedge clk_o) begin
        if (rst) blank <= 1'b0;
        else blank <= adv ? 1'b1 : (hold && blank);
    end
`else
    assign blank = 1'b0;
`endif
    // a wrap is reported on the first valid cycle of the new channel, so it waits out any blank
    always_ff @(posedge clk_o) begin
        if (rst) begin
            sel <= '0;
            pend <= 1'b0;
            out_c <= '0;
            out_sel <= '0;
            out_valid <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (adv) sel <= nxt;
            pend <= wrap || (blank && pend);
            out_c <= (cur_en && !blank) ? cur_word : '0;
            out_sel <= sel;
            out_valid <= cur_en && !blank;
            frame_start <= pend && any && !blank;
        end
    end
endmodule

// File: tb/tb_out_scheduler.sv
// tb_out_scheduler: scoreboard bench for out_scheduler with directed phases and a random tail.
module tb_out_scheduler;
    import out_sched_pkg::*;
    localparam int W = DEF_WIDTH;
    localparam int CH = DEF_CHANNELS;
    localparam int DW = DEF_DWELL;
    localparam int SW = $clog2(CH);
    localparam int DWID = CH * W;
`ifdef OUT_SCHED_BLANK_EN
    localparam int PER = DW + 1;
`else
    localparam int PER = DW;
`endif

    logic clk_o = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic [DWID-1:0] in_data = '0;
    logic [CH-1:0] en_mask = '0;
    logic [W-1:0] out_c;
    logic [SW-1:0] out_sel;
    logic out_valid, frame_start;

    out_scheduler #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) dut (
        .clk_o       (clk_o),
        .rst         (rst),
        .in_data     (in_data),
        .en_mask     (en_mask),
        .hold        (hold),
        .out_c       (out_c),
        .out_sel     (out_sel),
        .out_valid   (out_valid),
        .frame_start (frame_start)
    );

    always #5 clk_o = ~clk_o;

    typedef struct packed {
        logic [W-1:0]  c;
        logic [SW-1:0] s;
        logic          v;
        logic          f;
    } exp_t;

    exp_t q[$];
    int nvec = 0;
    int nerr = 0;
    int m_sel = 0;
    int m_cnt = 0;
    bit m_pend = 0;
    bit m_blank = 0;
    logic [W-1:0] log_c[32];
    logic log_f[32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Predict the outputs of the coming edge from the pre-edge model state, then check them after it.
    task automatic step();
        exp_t e;
        int n;
        bit adv, wrap, any, en_cur;
        wrap = 0;
        if (rst) begin
            e = '0;
            m_sel = 0;
            m_cnt = 0;
            m_pend = 0;
            m_blank = 0;
        end else begin
            any = |en_mask;
            en_cur = en_mask[m_sel];
            e.c = (en_cur && !m_blank) ? in_data[m_sel*W +: W] : '0;
            e.s = SW'(m_sel);
            e.v = en_cur && !m_blank;
            e.f = m_pend && any && !m_blank;
            adv = !hold && any && !m_blank && (m_cnt == DW - 1 || !en_cur);
            if (adv) begin
                n = m_sel;
                for (int i = CH; i >= 1; i--) if (en_mask[(m_sel + i) % CH]) n = (m_sel + i) % CH;
                wrap = n <= m_sel;
                m_sel = n;
                m_cnt = 0;
            end else if (!hold && any && !m_blank) m_cnt++;
            m_pend = wrap || (m_blank && m_pend);
`ifdef OUT_SCHED_BLANK_EN
            m_blank = adv || (hold && m_blank);
`endif
        end
        q.push_back(e);
        @(posedge clk_o);
        #1;
        e = q.pop_front();
        chk("out_c", 32'(out_c), 32'(e.c));
        chk("out_sel", 32'(out_sel), 32'(e.s));
        chk("out_valid", 32'(out_valid), 32'(e.v));
        chk("frame_start", 32'(frame_start), 32'(e.f));
    endtask

    initial begin
        rst = 1;
        en_mask = 4'b1111;
        in_data = {4'd4, 4'd3, 4'd2, 4'd1};
        repeat (2) step();
        chk("reset_out_c", 32'(out_c), 0);
        rst = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            log_c[i] = out_c;
            log_f[i] = frame_start;
        end
        for (int i = 0; i < 24; i++)
            chk("seq_c", 32'(log_c[i]), (i % PER == DW) ? 0 : 32'((i / PER) % CH + 1));
        chk("fs_initial", 32'(log_f[0]), 0);
        chk("fs_wrap", 32'(log_f[CH*PER]), 1);
        en_mask = 4'b1010;
        repeat (20) step();
        en_mask = 4'b1111;
        repeat (6) step();
        en_mask = 4'b1101;
        repeat (6) step();
        en_mask = '0;
        repeat (3) step();
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_out_c", 32'(out_c), 0);
        en_mask = 4'b1111;
        in_data = {4'd3, 4'd3, 4'd3, 4'd3};
        repeat (5) step();
        hold = 1;
        step();
        in_data = {4'd7, 4'd7, 4'd7, 4'd7};
        repeat (4) step();
        chk("hold_track", 32'(out_c), 7);
        hold = 0;
        repeat (12) step();
        in_data = {4'd4, 4'd3, 4'd2, 4'd1};
        repeat (3) step();
        rst = 1;
        step();
        chk("rst_sel", 32'(out_sel), 0);
        chk("rst_out_c", 32'(out_c), 0);
        rst = 0;
        repeat (8) step();
        en_mask = 4'b1110;
        rst = 1;
        step();
        rst = 0;
        repeat (8) step();
        en_mask = 4'b0100;
        repeat (12) step();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) en_mask = CH'($urandom);
            if ($urandom_range(0, 40) == 0) en_mask = '0;
            hold = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) in_data = DWID'($urandom);
            rst = ($urandom_range(0, 60) == 0);
            step();
        end
        rst = 0;
        hold = 0;
        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
